riscv_fetch_unit: RTL and testbench

//  Instruction-fetch stage feeding the RISC-V execute core. Reads the byte-wide

---
 rtl/riscv_fetch_unit_if.sv | 32 +++
 rtl/riscv_fetch_unit.sv | 107 ++++++++++
 tb/tb_riscv_fetch_unit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/riscv_fetch_unit_if.sv
// riscv_fetch_unit_if: fetch-unit bus bundle (imem byte port, instruction stream, redirect).
//   master = fetch unit: drives imem_req/imem_addr, out_valid/out_instr/out_pc (and fault).
//   slave  = environment: drives imem_rdata, out_ready, redirect_valid/redirect_pc.
//   The fault signal exists only when FETCH_FAULT_EN is defined.
interface riscv_fetch_unit_if #(parameter int XLEN = 64);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [7:0]      imem_rdata;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_pc;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
`ifdef FETCH_FAULT_EN
    logic            fault;
`endif
    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc,
`ifdef FETCH_FAULT_EN
        output fault,
`endif
        input imem_rdata, out_ready, redirect_valid, redirect_pc
    );
    modport slave (
        input imem_req, imem_addr, out_valid, out_instr, out_pc,
`ifdef FETCH_FAULT_EN
        input fault,
`endif
        output imem_rdata, out_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/riscv_fetch_unit.sv
// riscv_fetch_unit: byte-serial instruction fetch, big-endian word assembly, FIFO buffer, redirect.
//   clk, reset (sync, active-high); bus = riscv_fetch_unit_if.master.
//   Optional FETCH_FAULT_EN: misaligned redirect or out-of-range word raises sticky fault.
module riscv_fetch_unit #(
    parameter int              XLEN       = 64,
    parameter int              IMEM_DEPTH = 176,
    parameter int              FIFO_DEPTH = 2,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input logic                clk,
    input logic                reset,
    riscv_fetch_unit_if.master bus
);
    localparam int AW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    typedef enum logic [1:0] {FETCH, STALL, FAULT} state_e;
    state_e          state_q, state_d;
    logic [XLEN-1:0] ipc_q, apc_q, addr, target, lim;
    logic [1:0]      k_q, rk_q;
    logic            rvalid_q, roor_q, repoch_q, epoch_q;
    logic [23:0]     asm_q;
    logic [31:0]     instr_mem [FIFO_DEPTH];
    logic [XLEN-1:0] pc_mem [FIFO_DEPTH];
    logic [AW-1:0]   wp_q, rp_q;
    logic [CW-1:0]   cnt_q;
    logic            valid, byte_ok, push, pop, room, in_range, pc_bad, target_bad, issue;
    logic [7:0]      rbyte;
    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return p == AW'(FIFO_DEPTH - 1) ? '0 : p + AW'(1);
    endfunction
    assign lim      = XLEN'(IMEM_DEPTH);
    assign addr     = ipc_q + XLEN'(k_q);
    assign in_range = addr < lim;
    // a returning byte is used only if issued in the current epoch
    assign byte_ok  = rvalid_q && repoch_q == epoch_q;
    assign rbyte    = roor_q ? 8'h00 : bus.imem_rdata;
    assign push     = byte_ok && rk_q == 2'd3;
    assign valid    = cnt_q != '0;
    assign pop      = valid && bus.out_ready;
    // a word is "assembling" while bytes remain to issue or its last byte is returning
    assign room     = int'(cnt_q) - int'(pop) + int'(k_q != 2'd0 || byte_ok) < FIFO_DEPTH;
`ifdef FETCH_FAULT_EN
    assign pc_bad     = ipc_q + XLEN'(3) >= lim;
    assign target_bad = bus.redirect_pc[1:0] != 2'b00;
    assign target     = bus.redirect_pc;
    assign bus.fault  = state_q == FAULT;
`else
    assign pc_bad     = 1'b0;
    assign target_bad = 1'b0;
    assign target     = bus.redirect_pc & ~XLEN'(3);
`endif
    // room is only checked at byte 0, so a started word always completes
    assign issue   = !reset && state_q != FAULT && (k_q != 2'd0 || (room && !pc_bad));
    assign state_d = (state_q == FAULT || (k_q == 2'd0 && pc_bad)) ? FAULT :
                     (k_q == 2'd0 && !room) ? STALL : FETCH;
    assign bus.imem_req  = issue && in_range;
    assign bus.imem_addr = addr;
    assign bus.out_valid = valid;
    assign bus.out_instr = valid ? instr_mem[rp_q] : 32'h0;
    assign bus.out_pc    = valid ? pc_mem[rp_q] : '0;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FETCH;
            ipc_q    <= RESET_PC;
            apc_q    <= RESET_PC;
            k_q      <= '0;
            rk_q     <= '0;
            rvalid_q <= 1'b0;
            roor_q   <= 1'b0;
            repoch_q <= 1'b0;
            epoch_q  <= 1'b0;
            asm_q    <= '0;
            wp_q     <= '0;
            rp_q     <= '0;
            cnt_q    <= '0;
        end else begin
            rvalid_q <= issue;
            rk_q     <= k_q;
            roor_q   <= !in_range;
            repoch_q <= epoch_q;
            if (byte_ok) asm_q <= {asm_q[15:0], rbyte};
            if (bus.redirect_valid) begin
                state_q <= target_bad ? FAULT : FETCH;
                ipc_q   <= target;
                k_q     <= '0;
                epoch_q <= !epoch_q;
                wp_q    <= '0;
                rp_q    <= '0;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                if (issue) begin
                    k_q <= k_q + 2'd1;
                    if (k_q == 2'd0) apc_q <= ipc_q;
                    if (k_q == 2'd3) ipc_q <= ipc_q + XLEN'(4);
                end
                if (push) begin
                    instr_mem[wp_q] <= {asm_q, rbyte};
                    pc_mem[wp_q]    <= apc_q;
                    wp_q            <= nxt(wp_q);
                end
                if (pop) rp_q <= nxt(rp_q);
                cnt_q <= cnt_q + CW'(push) - CW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_riscv_fetch_unit.sv
// tb_riscv_fetch_unit: directed bench for riscv_fetch_unit with a byte-wide imem model.
module tb_riscv_fetch_unit;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       bad_req = 1'b0;
    logic [7:0] mem [0:175];
    int         vectors = 0;
    int         miscompares = 0;
    riscv_fetch_unit_if #(.XLEN(64)) bus ();
    riscv_fetch_unit #(.XLEN(64), .IMEM_DEPTH(176), .FIFO_DEPTH(2), .RESET_PC(64'h0)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    always #5 clk = ~clk;
    // out-of-range or idle reads return FF so a design that fails to zero them is caught
    always @(posedge clk) begin
        bus.imem_rdata <= (bus.imem_req && bus.imem_addr < 64'd176) ? mem[bus.imem_addr[7:0]] : 8'hFF;
        if (!reset && bus.imem_req && bus.imem_addr >= 64'd176) bad_req <= 1'b1;
    end
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    initial begin
        for (int i = 0; i < 176; i++) mem[i] = 8'(i);
        mem[0] = 8'h00; mem[1] = 8'hA0; mem[2] = 8'h00; mem[3] = 8'h93;
        bus.out_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 64'h0;
        tick(2);
        chk("rst_valid", 64'(bus.out_valid), 64'h0);
        chk("rst_req", 64'(bus.imem_req), 64'h0);
        chk("rst_instr", 64'(bus.out_instr), 64'h0);
        chk("rst_pc", bus.out_pc, 64'h0);
        reset = 1'b0; #1;
        chk("t1_req", 64'(bus.imem_req), 64'h1);
        chk("t1_addr", bus.imem_addr, 64'h0);
        tick(4);
        chk("t1_early", 64'(bus.out_valid), 64'h0);
        tick(1);
        chk("t1_valid", 64'(bus.out_valid), 64'h1);
        chk("t1_instr", 64'(bus.out_instr), 64'h00A00093);
        chk("t1_pc", bus.out_pc, 64'h0);
        tick(1);
        chk("t1_gap", 64'(bus.out_valid), 64'h0);
        tick(3);
        chk("t1_valid2", 64'(bus.out_valid), 64'h1);
        chk("t1_instr2", 64'(bus.out_instr), 64'h04050607);
        chk("t1_pc2", bus.out_pc, 64'h4);
        reset = 1'b1; bus.out_ready = 1'b0;
        tick(1);
        reset = 1'b0;
        tick(5);
        chk("t2_valid", 64'(bus.out_valid), 64'h1);
        chk("t2_pc0", bus.out_pc, 64'h0);
        tick(5);
        chk("t2_stall_req", 64'(bus.imem_req), 64'h0);
        chk("t2_hold_pc", bus.out_pc, 64'h0);
        tick(2);
        bus.out_ready = 1'b1; #1;
        chk("t2_resume_req", 64'(bus.imem_req), 64'h1);
        chk("t2_resume_addr", bus.imem_addr, 64'h8);
        chk("t2_pop_pc0", bus.out_pc, 64'h0);
        tick(1);
        bus.out_ready = 1'b0;
        chk("t2_pc1", bus.out_pc, 64'h4);
        chk("t2_instr1", 64'(bus.out_instr), 64'h04050607);
        tick(2);
        chk("t3_byte3_addr", bus.imem_addr, 64'hB);
        bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h40;
        tick(1);
        bus.redirect_valid = 1'b0; #1;
        chk("t3_flush", 64'(bus.out_valid), 64'h0);
        chk("t3_req", 64'(bus.imem_req), 64'h1);
        chk("t3_addr", bus.imem_addr, 64'h40);
        tick(1);
        chk("t3_stale", 64'(bus.out_valid), 64'h0);
        tick(3);
        chk("t3_early", 64'(bus.out_valid), 64'h0);
        tick(1);
        chk("t3_valid", 64'(bus.out_valid), 64'h1);
        chk("t3_pc", bus.out_pc, 64'h40);
        chk("t3_instr", 64'(bus.out_instr), 64'h40414243);
        tick(1);
        reset = 1'b1;
        tick(1);
        chk("t4_valid", 64'(bus.out_valid), 64'h0);
        chk("t4_pc", bus.out_pc, 64'h0);
        chk("t4_instr", 64'(bus.out_instr), 64'h0);
        chk("t4_req", 64'(bus.imem_req), 64'h0);
        reset = 1'b0; bus.out_ready = 1'b1; #1;
        chk("t4_restart_addr", bus.imem_addr, 64'h0);
        chk("t4_restart_req", 64'(bus.imem_req), 64'h1);
        tick(4);
        chk("t4_no_partial", 64'(bus.out_valid), 64'h0);
        tick(1);
        chk("t4_valid", 64'(bus.out_valid), 64'h1);
        chk("t4_instr", 64'(bus.out_instr), 64'h00A00093);
        chk("t4_pc0", bus.out_pc, 64'h0);
        tick(1);
        bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h42;
        tick(1);
        bus.redirect_valid = 1'b0; #1;
`ifdef FETCH_FAULT_EN
        chk("t5_fault", 64'(bus.fault), 64'h1);
        chk("t5_fault_req", 64'(bus.imem_req), 64'h0);
        bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h44;
        tick(1);
        bus.redirect_valid = 1'b0; #1;
        chk("t5_clear", 64'(bus.fault), 64'h0);
        chk("t5_addr", bus.imem_addr, 64'h44);
        tick(5);
        chk("t5_valid", 64'(bus.out_valid), 64'h1);
        chk("t5_pc", bus.out_pc, 64'h44);
        chk("t5_instr", 64'(bus.out_instr), 64'h44454647);
`else
        chk("t5_req", 64'(bus.imem_req), 64'h1);
        chk("t5_addr", bus.imem_addr, 64'h40);
        tick(5);
        chk("t5_valid", 64'(bus.out_valid), 64'h1);
        chk("t5_pc", bus.out_pc, 64'h40);
        chk("t5_instr", 64'(bus.out_instr), 64'h40414243);
`endif
        tick(1);
        bus.redirect_valid = 1'b1; bus.redirect_pc = 64'hA8;
        tick(1);
        bus.redirect_valid = 1'b0; #1;
        chk("t6_addr", bus.imem_addr, 64'hA8);
        tick(5);
        chk("t6_pc_a8", bus.out_pc, 64'hA8);
        chk("t6_instr_a8", 64'(bus.out_instr), 64'hA8A9AAAB);
        tick(4);
        chk("t6_pc_ac", bus.out_pc, 64'hAC);
        chk("t6_instr_ac", 64'(bus.out_instr), 64'hACADAEAF);
`ifdef FETCH_FAULT_EN
        chk("t6_fault", 64'(bus.fault), 64'h1);
`endif
        tick(1);
        chk("t6_oor_req", 64'(bus.imem_req), 64'h0);
        tick(3);
`ifdef FETCH_FAULT_EN
        chk("t6_fault_valid", 64'(bus.out_valid), 64'h0);
        chk("t6_fault_sticky", 64'(bus.fault), 64'h1);
`else
        chk("t6_valid_b0", 64'(bus.out_valid), 64'h1);
        chk("t6_pc_b0", bus.out_pc, 64'hB0);
        chk("t6_instr_b0", 64'(bus.out_instr), 64'h0);
        chk("t6_oor_req2", 64'(bus.imem_req), 64'h0);
`endif
        chk("oor_never_req", 64'(bad_req), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
